// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multicycle MIPS-compatible core: sequencer state
// encodings and the opcode/funct values the sequencer and controller decode.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    ST_HALTED = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC1  = 3'd3,
    ST_EXEC2  = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_BEQ    = 6'h04;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_ALU_LO = 6'h20;
  localparam logic [5:0] FN_ALU_HI = 6'h26;

endpackage

// File: rtl/mips_cpu_instr_class.sv
// Combinational instruction classifier shared by the sequencer and controller.
module mips_cpu_instr_class
  import mips_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] fncode,
  output logic       legal,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_jr_jalr
);

  logic is_rtype;
  logic is_alu;

  always_comb begin
    is_rtype   = (opcode == OP_RTYPE);
    is_alu     = is_rtype && (fncode >= FN_ALU_LO) && (fncode <= FN_ALU_HI);
    is_jr_jalr = is_rtype && ((fncode == FN_JR) || (fncode == FN_JALR));
    is_lw      = (opcode == OP_LW);
    is_sw      = (opcode == OP_SW);
    is_beq     = (opcode == OP_BEQ);
    legal      = is_alu || is_jr_jalr || is_lw || is_sw || is_beq;
  end

endmodule

// File: rtl/mips_cpu_sequencer.sv
// Multicycle state sequencer: memory stall handling, halt/fault detection and
// retired-instruction / active-cycle performance counters.
module mips_cpu_sequencer
  import mips_cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       fncode,
  input  logic             waitrequest,
  input  logic             jump_target_zero,
  output logic [2:0]       state,
  output logic             mem_req,
  output logic             active,
  output logic             fault,
  output logic [CNT_W-1:0] instr_retired,
  output logic [CNT_W-1:0] cycle_count
);

  state_t state_q;
  state_t state_d;
  logic   legal;
  logic   is_lw;
  logic   is_sw;
  logic   is_beq;
  logic   is_jr_jalr;
  logic   stall;
  logic   retire;

  mips_cpu_instr_class u_instr_class (
    .opcode     (opcode),
    .fncode     (fncode),
    .legal      (legal),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_beq     (is_beq),
    .is_jr_jalr (is_jr_jalr)
  );

  assign state = state_q;

  always_comb begin
    mem_req = (state_q == ST_FETCH) ||
              ((state_q == ST_EXEC1) && is_lw) ||
              ((state_q == ST_EXEC2) && is_sw);
    stall   = mem_req && waitrequest;
    // Retirement happens on leaving the last exec state, so a stalled sw
    // retires only on the cycle its EXEC2 actually completes.
    retire  = !stall && (((state_q == ST_EXEC1) && is_beq) || (state_q == ST_EXEC2));
  end

  always_comb begin
    state_d = state_q;
    if (!stall) begin
      unique case (state_q)
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: state_d = legal ? ST_EXEC1 : ST_FAULT;
        ST_EXEC1:  state_d = is_beq ? ST_FETCH : ST_EXEC2;
        ST_EXEC2:  state_d = (is_jr_jalr && jump_target_zero) ? ST_HALTED : ST_FETCH;
        ST_HALTED: state_d = ST_HALTED;
        ST_FAULT:  state_d = ST_FAULT;
        default:   state_d = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      active        <= 1'b1;
      fault         <= 1'b0;
      instr_retired <= '0;
      cycle_count   <= '0;
    end else begin
      state_q <= state_d;
      active  <= (state_d != ST_HALTED) && (state_d != ST_FAULT);
      fault   <= (state_d == ST_FAULT);
      if (retire) begin
        instr_retired <= instr_retired + 1'b1;
      end
      if (active) begin
        cycle_count <= cycle_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Directed self-checking bench for mips_cpu_sequencer.
module tb_mips_cpu_sequencer;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  fncode;
  logic        waitrequest;
  logic        jump_target_zero;
  logic [2:0]  state;
  logic        mem_req;
  logic        active;
  logic        fault;
  logic [31:0] instr_retired;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  mips_cpu_sequencer #(.CNT_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .opcode           (opcode),
    .fncode           (fncode),
    .waitrequest      (waitrequest),
    .jump_target_zero (jump_target_zero),
    .state            (state),
    .mem_req          (mem_req),
    .active           (active),
    .fault            (fault),
    .instr_retired    (instr_retired),
    .cycle_count      (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input int exp_st, input bit exp_mreq);
    check({tag, ".state"}, 32'(state), 32'(exp_st));
    check({tag, ".mem_req"}, 32'(mem_req), 32'(exp_mreq));
  endtask

  task automatic chk_cnt(input string tag, input int exp_ret, input int exp_cyc);
    check({tag, ".retired"}, instr_retired, 32'(exp_ret));
    check({tag, ".cycles"}, cycle_count, 32'(exp_cyc));
  endtask

  initial begin
    reset = 1'b1;
    opcode = 6'h00;
    fncode = 6'h21;
    waitrequest = 1'b0;
    jump_target_zero = 1'b0;
    step();
    chk_st("rst", 1, 1'b1);
    check("rst.active", 32'(active), 32'd1);
    check("rst.fault", 32'(fault), 32'd0);
    chk_cnt("rst", 0, 0);

    // addu
    reset = 1'b0;
    step(); chk_st("addu.c1", 2, 1'b0);
    step(); chk_st("addu.c2", 3, 1'b0);
    step(); chk_st("addu.c3", 4, 1'b0);
    step(); chk_st("addu.c4", 1, 1'b1);
    chk_cnt("addu", 1, 4);

    // lw: 2 wait cycles in FETCH, 3 in EXEC1
    opcode = 6'h23; fncode = 6'h00; waitrequest = 1'b1;
    step(); chk_st("lw.fw1", 1, 1'b1);
    step(); chk_st("lw.fw2", 1, 1'b1);
    waitrequest = 1'b0;
    step(); chk_st("lw.dec", 2, 1'b0);
    step(); chk_st("lw.ex1", 3, 1'b1);
    waitrequest = 1'b1;
    step(); chk_st("lw.ew1", 3, 1'b1);
    step(); chk_st("lw.ew2", 3, 1'b1);
    step(); chk_st("lw.ew3", 3, 1'b1);
    waitrequest = 1'b0;
    step(); chk_st("lw.ex2", 4, 1'b0);
    step(); chk_st("lw.done", 1, 1'b1);
    chk_cnt("lw", 2, 13);

    // beq: waitrequest in EXEC1 must be ignored (no memory access)
    opcode = 6'h04;
    step(); chk_st("beq.dec", 2, 1'b0);
    step(); chk_st("beq.ex1", 3, 1'b0);
    waitrequest = 1'b1;
    step(); chk_st("beq.done", 1, 1'b1);
    waitrequest = 1'b0;
    chk_cnt("beq", 3, 16);

    // sw: 1 wait cycle in EXEC2
    opcode = 6'h2B;
    step(); chk_st("sw.dec", 2, 1'b0);
    step(); chk_st("sw.ex1", 3, 1'b0);
    step(); chk_st("sw.ex2a", 4, 1'b1);
    waitrequest = 1'b1;
    check("sw.notyet", instr_retired, 32'd3);
    step(); chk_st("sw.ex2b", 4, 1'b1);
    waitrequest = 1'b0;
    step(); chk_st("sw.done", 1, 1'b1);
    chk_cnt("sw", 4, 21);

    // IR garbage during FETCH has no effect; JR with target 0 halts
    opcode = 6'h3F;
    jump_target_zero = 1'b1;
    step(); chk_st("jr.dec", 2, 1'b0);
    opcode = 6'h00; fncode = 6'h08;
    step(); chk_st("jr.ex1", 3, 1'b0);
    step(); chk_st("jr.ex2", 4, 1'b0);
    step(); chk_st("jr.halt", 0, 1'b0);
    check("jr.active", 32'(active), 32'd0);
    chk_cnt("jr", 5, 25);
    waitrequest = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk_st("halt.hold", 0, 1'b0);
    chk_cnt("halt.frozen", 5, 25);
    waitrequest = 1'b0;

    // illegal opcode -> FAULT
    reset = 1'b1; step(); reset = 1'b0;
    chk_cnt("rst2", 0, 0);
    opcode = 6'h3F;
    step(); chk_st("ill.dec", 2, 1'b0);
    step(); chk_st("ill.fault", 5, 1'b0);
    check("ill.fault_o", 32'(fault), 32'd1);
    check("ill.active", 32'(active), 32'd0);
    step(); step();
    chk_st("ill.hold", 5, 1'b0);
    chk_cnt("ill", 0, 2);
    reset = 1'b1; step(); reset = 1'b0;
    chk_st("ill.rst", 1, 1'b1);
    check("ill.rst.fault", 32'(fault), 32'd0);
    chk_cnt("ill.rst", 0, 0);

    // R-type funct just above the ALU range is illegal
    opcode = 6'h00; fncode = 6'h27; jump_target_zero = 1'b0;
    step(); step(); chk_st("fn27", 5, 1'b0);

    // JALR with nonzero target continues
    reset = 1'b1; step(); reset = 1'b0;
    fncode = 6'h09;
    step(); step(); step(); step();
    chk_st("jalr", 1, 1'b1);
    chk_cnt("jalr", 1, 4);

    // reset during an EXEC1 lw stall
    opcode = 6'h23; fncode = 6'h00;
    step(); step(); chk_st("lwr.ex1", 3, 1'b1);
    waitrequest = 1'b1;
    step(); chk_st("lwr.stall", 3, 1'b1);
    reset = 1'b1;
    step(); chk_st("lwr.rst", 1, 1'b1);
    chk_cnt("lwr.rst", 0, 0);
    reset = 1'b0;
    step(); chk_st("lwr.hold1", 1, 1'b1);
    step(); chk_st("lwr.hold2", 1, 1'b1);
    check("lwr.cycles", cycle_count, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
